// File: rtl/joy_serial_reader.sv
// joy_serial_reader: drives a 74HC165-style PISO chain, deserialises
// every frame and debounces each bit over FILTER agreeing frames.
module joy_serial_reader #(
  parameter int CLKDIV     = 14,
  parameter int NCHAN      = 2,
  parameter int NBITS      = 8,
  parameter int FILTER     = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   joy_data,
  output logic                   joy_clk,
  output logic                   joy_load_n,
  output logic [NCHAN*NBITS-1:0] joy_state,
  output logic                   frame_done,
  output logic [NCHAN-1:0]       changed
);

  localparam int N  = NCHAN * NBITS;
  localparam int PW = $clog2(CLKDIV);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(FILTER) + 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SAMPLE,
    S_CLK_HI,
    S_DONE
  } st_e;

  st_e                  st_q;
  logic [PW-1:0]        ph_q;
  logic [KW-1:0]        k_q;
  logic [N-1:0]         raw_q;
  logic [N-1:0][CW-1:0] cnt_q;
  logic [N-1:0][CW-1:0] cnt_d;
  logic [N-1:0]         state_q;
  logic [N-1:0]         state_d;
  logic [N-1:0]         tog;
  logic [NCHAN-1:0]     chg_q;
  logic [NCHAN-1:0]     chg_d;
  logic                 done_q;
  logic                 clk_q;
  logic                 load_n_q;

  logic          tick;
  logic          bit_in;
  logic          last_k;
  logic [KW-1:0] idx;

  assign tick   = (ph_q == PW'(CLKDIV - 1));
  assign bit_in = joy_data ^ ACTIVE_LOW;
  assign last_k = (k_q == KW'(N - 1));
  assign idx    = KW'(N - 1) - k_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog     = '0;
    for (int i = 0; i < N; i++) begin
      if (raw_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(FILTER - 1)) begin
        state_d[i] = ~state_q[i];
        cnt_d[i]   = '0;
        tog[i]     = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    chg_d = '0;
    for (int c = 0; c < NCHAN; c++) begin
      chg_d[c] = |tog[c*NBITS +: NBITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= S_LOAD;
      ph_q     <= '0;
      k_q      <= '0;
      raw_q    <= '0;
      cnt_q    <= '0;
      state_q  <= '0;
      chg_q    <= '0;
      done_q   <= 1'b0;
      clk_q    <= 1'b0;
      load_n_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      chg_q  <= '0;
      unique case (st_q)
        S_LOAD: begin
          // first cycle after reset only drops load, so it stays low CLKDIV cycles
          if (load_n_q) begin
            load_n_q <= 1'b0;
          end else if (tick) begin
            ph_q     <= '0;
            k_q      <= '0;
            load_n_q <= 1'b1;
            st_q     <= S_SAMPLE;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        S_SAMPLE: begin
          if (tick) begin
            ph_q       <= '0;
            raw_q[idx] <= bit_in;
            clk_q      <= 1'b1;
            st_q       <= S_CLK_HI;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        S_CLK_HI: begin
          if (tick) begin
            ph_q  <= '0;
            clk_q <= 1'b0;
            if (last_k) begin
              st_q <= S_DONE;
            end else begin
              k_q  <= k_q + KW'(1);
              st_q <= S_SAMPLE;
            end
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        S_DONE: begin
          state_q  <= state_d;
          cnt_q    <= cnt_d;
          chg_q    <= chg_d;
          done_q   <= 1'b1;
          ph_q     <= '0;
          load_n_q <= 1'b0;
          st_q     <= S_LOAD;
        end
      endcase
    end
  end

  assign joy_clk    = clk_q;
  assign joy_load_n = load_n_q;
  assign joy_state  = state_q;
  assign frame_done = done_q;
  assign changed    = chg_q;

endmodule

// File: tb/tb_joy_serial_reader.sv
// tb_joy_serial_reader: two instances (unfiltered active-low, filtered
// active-high) each driven by a behavioural 165 chain.
module tb_joy_serial_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        dat_a, dat_b;
  logic        jclk_a, jclk_b;
  logic        ld_a, ld_b;
  logic [15:0] st_a, st_b;
  logic        fd_a, fd_b;
  logic [1:0]  ch_a, ch_b;

  logic [15:0] pat_a = 16'hFFFF;
  logic [15:0] pat_b = 16'h0000;
  logic [15:0] sr_a = '0;
  logic [15:0] sr_b = '0;
  logic        jq_a = 1'b0;
  logic        jq_b = 1'b0;

  int n_run  = 0;
  int n_fail = 0;

  joy_serial_reader #(
    .CLKDIV(4), .NCHAN(2), .NBITS(8), .FILTER(1), .ACTIVE_LOW(1'b1)
  ) u_a (
    .clk(clk), .rst(rst_a), .joy_data(dat_a),
    .joy_clk(jclk_a), .joy_load_n(ld_a), .joy_state(st_a),
    .frame_done(fd_a), .changed(ch_a)
  );

  joy_serial_reader #(
    .CLKDIV(4), .NCHAN(2), .NBITS(8), .FILTER(3), .ACTIVE_LOW(1'b0)
  ) u_b (
    .clk(clk), .rst(rst_b), .joy_data(dat_b),
    .joy_clk(jclk_b), .joy_load_n(ld_b), .joy_state(st_b),
    .frame_done(fd_b), .changed(ch_b)
  );

  // chain model: parallel load while load_n low, shift on joy_clk rise
  assign dat_a = sr_a[15];
  assign dat_b = sr_b[15];

  always @(posedge clk) begin
    jq_a <= jclk_a;
    if (!ld_a) sr_a <= pat_a;
    else if (jclk_a && !jq_a) sr_a <= {sr_a[14:0], 1'b0};
  end

  always @(posedge clk) begin
    jq_b <= jclk_b;
    if (!ld_b) sr_b <= pat_b;
    else if (jclk_b && !jq_b) sr_b <= {sr_b[14:0], 1'b0};
  end

  int cyc = 0, fd_cyc = 0, per_a = 0;
  int pulses = 0, pulses_per = 0;
  int hi_len = 0, bad_len = 0, overlap = 0;
  logic jp = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    jp  <= jclk_a;
    if (jclk_a) hi_len <= hi_len + 1;
    if (!jclk_a && jp) begin
      if (hi_len != 4) bad_len <= bad_len + 1;
      hi_len <= 0;
    end
    if (jclk_a && !ld_a) overlap <= overlap + 1;
    if (fd_a) begin
      per_a      <= cyc - fd_cyc;
      fd_cyc     <= cyc;
      pulses_per <= pulses;
      pulses     <= 0;
    end else if (jclk_a && !jp) begin
      pulses <= pulses + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(input bit use_b);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (use_b ? fd_b : fd_a) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("fd_timeout", 32'd0, 32'd1);
  endtask

  task automatic meas_load_a(input string tag);
    int  lo;
    bit  seen;
    lo   = 0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!ld_a) begin
        seen = 1'b1;
        lo++;
      end else if (seen) begin
        break;
      end
    end
    chk(tag, lo, 4);
  endtask

  task automatic frame_b(input string tag, input logic [15:0] es,
                         input logic [1:0] ec);
    wait_fd(1'b1);
    chk({tag, "_st"}, st_b, es);
    chk({tag, "_ch"}, ch_b, ec);
  endtask

  initial begin
    int nf;
    bit prev;
    rst_a = 1'b1;
    rst_b = 1'b1;
    pat_a = 16'h7FFF;
    pat_b = 16'h0000;
    #12;
    chk("rst_ld", ld_a, 1);
    chk("rst_jclk", jclk_a, 0);
    chk("rst_st", st_a, 0);
    chk("rst_fd", fd_a, 0);
    chk("rst_ch", ch_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    meas_load_a("load_lo_init");

    wait_fd(1'b0);
    chk("map_st", st_a, 16'h8000);
    chk("map_ch", ch_a, 2'b10);
    wait_fd(1'b0);
    chk("map_st2", st_a, 16'h8000);
    chk("map_ch2", ch_a, 2'b00);
    pat_a = 16'h00FF;
    @(negedge clk);
    chk("period", per_a, 133);
    chk("pulses", pulses_per, 16);
    chk("pulse_len", bad_len, 0);
    chk("clk_in_load", overlap, 0);

    wait_fd(1'b0);
    chk("vec1_st", st_a, 16'hFF00);
    chk("vec1_ch", ch_a, 2'b10);
    pat_a = 16'hFFFE;
    wait_fd(1'b0);
    chk("vec2_st", st_a, 16'h0001);
    chk("vec2_ch", ch_a, 2'b11);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (jclk_a) break;
    end
    #1 rst_a = 1'b1;
    #1;
    chk("async_jclk", jclk_a, 0);
    chk("async_ld", ld_a, 1);
    chk("async_st", st_a, 0);
    chk("async_fd", fd_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    meas_load_a("load_lo_rst");
    wait_fd(1'b0);
    chk("rst_refill_st", st_a, 16'h0001);
    chk("rst_refill_ch", ch_a, 2'b01);

    wait_fd(1'b1);
    chk("b_idle", st_b, 0);
    pat_b = 16'h0010;
    frame_b("glitch1", 16'h0000, 2'b00);
    frame_b("glitch2", 16'h0000, 2'b00);
    pat_b = 16'h0000;
    frame_b("glitch_end", 16'h0000, 2'b00);
    pat_b = 16'h0010;
    frame_b("hold1", 16'h0000, 2'b00);
    frame_b("hold2", 16'h0000, 2'b00);
    frame_b("hold3", 16'h0010, 2'b01);
    pat_b = 16'h0011;
    frame_b("pol1", 16'h0010, 2'b00);
    frame_b("pol2", 16'h0010, 2'b00);
    frame_b("pol3", 16'h0011, 2'b01);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!ld_b) break;
    end
    nf   = 0;
    prev = 1'b0;
    for (int i = 0; i < 400 && nf < 5; i++) begin
      @(negedge clk);
      if (prev && !jclk_b) nf++;
      prev = jclk_b;
    end
    chk("k5_reached", nf, 5);
    @(negedge clk);
    #1 rst_b = 1'b1;
    #1;
    chk("mid_st", st_b, 0);
    chk("mid_jclk", jclk_b, 0);
    chk("mid_ld", ld_b, 1);
    @(negedge clk);
    rst_b = 1'b0;
    frame_b("re1", 16'h0000, 2'b00);
    frame_b("re2", 16'h0000, 2'b00);
    frame_b("re3", 16'h0011, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
